// File: rtl/sps_pkg.sv
// Shared definitions for the phase sequencer and the decode controller:
// state encoding, phase numbers, opcode fields and the write-back predicate.
package sps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MEMW = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [2:0] PH_IF  = 3'd0;
  localparam logic [2:0] PH_ID  = 3'd1;
  localparam logic [2:0] PH_EX  = 3'd2;
  localparam logic [2:0] PH_MEM = 3'd3;
  localparam logic [2:0] PH_WB  = 3'd4;

  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_ST  = 2'b01;
  localparam logic [1:0] OP1_LI  = 2'b10;
  localparam logic [1:0] OP1_ALU = 2'b11;
  localparam logic [2:0] OP2_LI  = 3'b000;
  localparam logic [3:0] OP3_CMP = 4'b0101;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  function automatic logic [1:0] f_op1(input logic [15:0] instr);
    return instr[15:14];
  endfunction

  function automatic logic [2:0] f_op2(input logic [15:0] instr);
    return instr[13:11];
  endfunction

  function automatic logic [3:0] f_op3(input logic [15:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic is_ld(input logic [15:0] instr);
    return f_op1(instr) == OP1_LD;
  endfunction

  function automatic logic is_st(input logic [15:0] instr);
    return f_op1(instr) == OP1_ST;
  endfunction

  function automatic logic is_hlt(input logic [15:0] instr);
    return (f_op1(instr) == OP1_ALU) && (f_op3(instr) == OP3_HLT);
  endfunction

  // CMP, OUT and HLT in the ALU group produce no register result; the
  // all-zero word is a NOP even though it decodes as LD.
  function automatic logic is_wb(input logic [15:0] instr);
    logic w_alu_wb;
    logic w_li_wb;
    w_alu_wb = (f_op1(instr) == OP1_ALU) &&
               (f_op3(instr) != OP3_CMP) &&
               (f_op3(instr) != OP3_OUT) &&
               (f_op3(instr) != OP3_HLT);
    w_li_wb  = (f_op1(instr) == OP1_LI) && (f_op2(instr) == OP2_LI);
    return (instr != 16'h0000) && ((f_op1(instr) == OP1_LD) || w_alu_wb || w_li_wb);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Load/count/expire timer bounding the wait for a data-memory acknowledge.
// expire is combinational: high on the TMO-th enabled cycle after load.
module mem_wait_timer #(
  parameter int TMO = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [W-1:0] LAST = W'(TMO - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase IF/ID/EX/MEM/WB sequencer with run/stop, HLT and memory timeout.
// Optional single-step input is enabled by defining PHASE_SINGLE_STEP_EN.
module phase_sequencer
  import sps_pkg::*;
#(
  parameter int MEM_TMO = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
`ifdef PHASE_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [15:0]      instr,
  input  logic             mem_ack,
  output logic [2:0]       phase,
  output logic [4:0]       phase_bus,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             running,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_phase;
  logic [2:0]       w_phase_nxt;
  logic             r_stop_pend;
  logic             w_stop_pend_nxt;
  logic             r_fault;
  logic             w_fault_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  logic w_step;
  logic w_active;
  logic w_is_ld;
  logic w_is_st;
  logic w_is_hlt;
  logic w_wb_en;
  logic w_mem_op;
  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_expire;

`ifdef PHASE_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b0;
`endif

  assign w_active = (r_state == ST_RUN) || (r_state == ST_MEMW);
  assign w_is_ld  = is_ld(instr);
  assign w_is_st  = is_st(instr);
  assign w_is_hlt = is_hlt(instr);
  assign w_wb_en  = is_wb(instr);
  assign w_mem_op = w_is_ld || w_is_st;

  // The timer starts counting on the first MEMW cycle, not the request cycle.
  assign w_tmr_load = (r_state == ST_RUN) && (r_phase == PH_MEM) && w_mem_op && !mem_ack;
  assign w_tmr_en   = (r_state == ST_MEMW) && !mem_ack;

  mem_wait_timer #(
    .TMO (MEM_TMO)
  ) u_mem_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (w_tmr_load),
    .en     (w_tmr_en),
    .expire (w_tmr_expire)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_stop_pend_nxt = r_stop_pend;
    w_fault_nxt     = r_fault;
    w_retire        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_step) begin
          w_state_nxt     = ST_RUN;
          w_phase_nxt     = PH_IF;
          w_stop_pend_nxt = 1'b1;
        end else if (exec) begin
          w_state_nxt     = ST_RUN;
          w_phase_nxt     = PH_IF;
          w_stop_pend_nxt = 1'b0;
        end
      end

      ST_RUN: begin
        if (exec) begin
          w_stop_pend_nxt = 1'b1;
        end
        case (r_phase)
          PH_IF, PH_ID, PH_EX: begin
            w_phase_nxt = r_phase + 3'd1;
          end
          PH_MEM: begin
            if (w_mem_op && !mem_ack) begin
              w_state_nxt = ST_MEMW;
            end else begin
              w_phase_nxt = PH_WB;
            end
          end
          PH_WB: begin
            w_retire    = 1'b1;
            w_phase_nxt = PH_IF;
            // A stop request arriving in WB still lands on this boundary.
            if (w_is_hlt) begin
              w_state_nxt     = ST_HALT;
              w_stop_pend_nxt = 1'b0;
            end else if (r_stop_pend || exec) begin
              w_state_nxt     = ST_IDLE;
              w_stop_pend_nxt = 1'b0;
            end
          end
          default: begin
            w_state_nxt     = ST_IDLE;
            w_phase_nxt     = PH_IF;
            w_stop_pend_nxt = 1'b0;
          end
        endcase
      end

      ST_MEMW: begin
        if (exec) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (mem_ack) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = PH_WB;
        end else if (w_tmr_expire) begin
          w_state_nxt     = ST_HALT;
          w_phase_nxt     = PH_IF;
          w_stop_pend_nxt = 1'b0;
          w_fault_nxt     = 1'b1;
        end
      end

      ST_HALT: begin
        // A faulted sequencer is only recoverable through reset.
        if (!r_fault) begin
          if (w_step) begin
            w_state_nxt     = ST_RUN;
            w_phase_nxt     = PH_IF;
            w_stop_pend_nxt = 1'b1;
          end else if (exec) begin
            w_state_nxt     = ST_RUN;
            w_phase_nxt     = PH_IF;
            w_stop_pend_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_phase_nxt     = PH_IF;
        w_stop_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_IF;
      r_stop_pend <= 1'b0;
      r_fault     <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_fault     <= w_fault_nxt;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign phase     = w_active ? r_phase : PH_IF;
  assign phase_bus = w_active ? (5'd1 << r_phase) : 5'd0;
  assign ir_we     = w_active && (r_phase == PH_IF);
  assign mem_req   = w_active && (r_phase == PH_MEM) && w_mem_op;
  assign mem_we    = mem_req && w_is_st;
  assign reg_we    = w_active && (r_phase == PH_WB) && w_wb_en;
  assign pc_we     = w_active && (r_phase == PH_WB) && !w_is_hlt;
  assign running   = w_active;
  assign halted    = (r_state == ST_HALT);
  assign fault     = r_fault;
  assign retired   = r_retired;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: stimulus queues the expected per-cycle strobe pattern,
// a negedge monitor pops it for every running cycle and checks idle quietness.
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec;
  logic [15:0] instr;
  logic        mem_ack;
`ifdef PHASE_SINGLE_STEP_EN
  logic        step;
`endif
  logic [2:0]  phase;
  logic [4:0]  phase_bus;
  logic        ir_we;
  logic        pc_we;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic        running;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  phase_sequencer #(
    .MEM_TMO (15),
    .CNT_W   (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .exec      (exec),
`ifdef PHASE_SINGLE_STEP_EN
    .step      (step),
`endif
    .instr     (instr),
    .mem_ack   (mem_ack),
    .phase     (phase),
    .phase_bus (phase_bus),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .reg_we    (reg_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .running   (running),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] bus;
    logic       ir;
    logic       pc;
    logic       rg;
    logic       mr;
    logic       mw;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  function automatic obs_t mk(input int ph, input logic ir, input logic pc,
                              input logic rg, input logic mr, input logic mw);
    obs_t o;
    o.ph  = 3'(ph);
    o.bus = 5'd1 << ph;
    o.ir  = ir;
    o.pc  = pc;
    o.rg  = rg;
    o.mr  = mr;
    o.mw  = mw;
    return o;
  endfunction

  always @(negedge clock) begin
    obs_t act;
    obs_t e;
    if (mon_en) begin
      act = {phase, phase_bus, ir_we, pc_we, reg_we, mem_req, mem_we};
      checks++;
      if (running) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_run_cycle act=%h req=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL phase_cycle act(ph bus ir pc rg mr mw)=%0d %b %b%b%b%b%b req=%0d %b %b%b%b%b%b",
                     act.ph, act.bus, act.ir, act.pc, act.rg, act.mr, act.mw,
                     e.ph, e.bus, e.ir, e.pc, e.rg, e.mr, e.mw);
          end
        end
      end else if (act !== '0) begin
        errors++;
        $display("FAIL idle_quiet act=%h req=0", act);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    exec    = 1'b0;
    mem_ack = 1'b0;
    instr   = 16'h0000;
`ifdef PHASE_SINGLE_STEP_EN
    step    = 1'b0;
`endif
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    chk("rst_phase",   32'(phase), 0);
    chk("rst_bus",     32'(phase_bus), 0);
    chk("rst_strobes", 32'({ir_we, pc_we, reg_we, mem_req, mem_we}), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_halted",  32'(halted), 0);
    chk("rst_fault",   32'(fault), 0);
    chk("rst_retired", 32'(retired), 0);

    // HLT: five phases, no PC or register write, then HALT.
    instr = 16'hC0F0;
    for (int p = 0; p < 5; p++) exp_q.push_back(mk(p, p == 0, 1'b0, 1'b0, 1'b0, 1'b0));
    exec = 1'b1; tick(); exec = 1'b0;
    repeat (5) tick();
    chk("hlt_halted",  32'(halted), 1);
    chk("hlt_running", 32'(running), 0);
    chk("hlt_retired", 32'(retired), 1);
    chk("hlt_drained", 32'(exp_q.size()), 0);

    // LD resumed from HALT, ack on the third MEMW cycle together with a stop.
    instr = 16'h0123;
    exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    exec = 1'b1; tick(); exec = 1'b0;
    repeat (6) tick();
    mem_ack = 1'b1; exec = 1'b1; tick(); mem_ack = 1'b0; exec = 1'b0;
    chk("ld_wb_phase", 32'(phase), 4);
    tick();
    chk("ld_running", 32'(running), 0);
    chk("ld_halted",  32'(halted), 0);
    chk("ld_retired", 32'(retired), 2);
    chk("ld_drained", 32'(exp_q.size()), 0);

    // CMP with exec in phase 2 and again in phase 3: stops after WB.
    instr = 16'hC050;
    for (int p = 0; p < 5; p++) exp_q.push_back(mk(p, p == 0, p == 4, 1'b0, 1'b0, 1'b0));
    exec = 1'b1; tick(); exec = 1'b0;
    tick(); tick();
    exec = 1'b1; tick(); tick(); exec = 1'b0;
    tick();
    chk("cmp_running", 32'(running), 0);
    chk("cmp_bus",     32'(phase_bus), 0);
    chk("cmp_retired", 32'(retired), 3);
    chk("cmp_drained", 32'(exp_q.size()), 0);

    // Reset during MEMW; a late ack afterwards changes nothing.
    instr = 16'h0123;
    exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    exec = 1'b1; tick(); exec = 1'b0;
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstm_running", 32'(running), 0);
    chk("rstm_strobes", 32'({ir_we, pc_we, reg_we, mem_req, mem_we}), 0);
    chk("rstm_retired", 32'(retired), 0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    tick();
    chk("late_ack_running", 32'(running), 0);
    chk("late_ack_halted",  32'(halted), 0);
    chk("rstm_drained",     32'(exp_q.size()), 0);

    // ST with no ack: fault after 15 MEMW cycles, sticky until reset.
    instr = 16'h4123;
    exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exec = 1'b1; tick(); exec = 1'b0;
    repeat (18) tick();
    chk("st_pre_fault",   32'(fault), 0);
    chk("st_pre_running", 32'(running), 1);
    tick();
    chk("st_fault",   32'(fault), 1);
    chk("st_halted",  32'(halted), 1);
    chk("st_mem_req", 32'(mem_req), 0);
    chk("st_retired", 32'(retired), 0);
    exec = 1'b1; tick(); exec = 1'b0;
    tick();
    chk("fault_exec_ignored", 32'(running), 0);
    chk("fault_sticky",       32'(fault), 1);
    chk("st_drained",         32'(exp_q.size()), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    chk("fault_cleared",  32'(fault), 0);
    chk("halt_cleared",   32'(halted), 0);

`ifdef PHASE_SINGLE_STEP_EN
    // Single step on LI, with exec in the same cycle losing to step.
    instr = 16'h8000;
    for (int p = 0; p < 5; p++) exp_q.push_back(mk(p, p == 0, p == 4, p == 4, 1'b0, 1'b0));
    step = 1'b1; exec = 1'b1; tick(); step = 1'b0; exec = 1'b0;
    repeat (5) tick();
    chk("step_running", 32'(running), 0);
    chk("step_halted",  32'(halted), 0);
    chk("step_retired", 32'(retired), 1);
    chk("step_drained", 32'(exp_q.size()), 0);
`endif

    tick();
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle phase sequencer for the 16-bit simple processor.
- Steps every instruction through five phases: IF, ID, EX, MEM, WB.
- Issues the per-phase register/memory write strobes and runs the data-memory request handshake.
- Handles run/stop from `exec` and halts on HLT. Sits beside the combinational decode controller and gates its RegWrite/PCSrc-class decisions into time.

Parameters:
- `MEM_TMO`, 15: maximum wait cycles in MEM for `mem_ack` before a fault.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `exec`  in  1  one-cycle run/stop pulse
- `instr`  in  16  current instruction register contents, stable from ID to WB
- `mem_ack`  in  1  data memory completion for the current request
- `phase`  out  3  current phase, 0..4 (IF..WB)
- `phase_bus`  out  5  one-hot of `phase`; all zero when not running
- `ir_we`  out  1  instruction register load
- `pc_we`  out  1  program counter update
- `reg_we`  out  1  register file write
- `mem_req`  out  1  data memory request
- `mem_we`  out  1  data memory write qualifier
- `running`  out  1  sequencer in RUN or MEMW
- `halted`  out  1  HLT retired or memory fault
- `fault`  out  1  memory timeout occurred (sticky)
- `retired`  out  `CNT_W`  count of retired instructions

Behaviour:
- Decode fields: `op1` = instr[15:14], `op2` = instr[13:11], `op3` = instr[7:4].
  - LD: `op1`=00.
  - ST: `op1`=01.
  - HLT: `op1`=11 and `op3`=1111.
- `wb_en` is true when `instr` != 0 and any of:
  - `op1`=00;
  - `op1`=11 and `op3` is not in {0101, 1101, 1111};
  - `op1`=10 and `op2`=000.
- States: IDLE, RUN, MEMW, HALT.
  - Reset: state IDLE, `phase`=0, `stop_pend`=0, `fault`=0, `retired`=0.
  - After reset all outputs are 0.
- IDLE: an `exec` pulse moves to RUN with `phase`=0 on the next cycle.
- RUN: `phase` advances by 1 each clock, with these exceptions:
  - Phase 3 (MEM) with LD or ST: `mem_req`=1 that cycle, and the next state is MEMW unless `mem_ack` is already 1. If it is, advance directly to phase 4.
  - Phase 4 (WB), the instruction retires: `retired` increments, wrapping at 2^`CNT_W`. Then:
    - HLT goes to HALT.
    - Else `stop_pend` set goes to IDLE and clears `stop_pend`.
    - Else `phase`=0, staying in RUN.
- MEMW: holds `phase`=3 and `mem_req`=1 with a wait counter.
  - `mem_ack`=1 means `phase`=4 next cycle.
  - After `MEM_TMO` cycles without ack: set `fault`, go to HALT, drop `mem_req`.
- Strobes are combinational from the registered state, `phase` and `instr`:
  - `ir_we`=1 in phase 0.
  - `mem_we` = `mem_req` and ST.
  - `reg_we`=1 in phase 4 when `wb_en`.
  - `pc_we`=1 in phase 4, except for HLT.
  - All strobes are 0 outside RUN/MEMW.
- `exec` in RUN or MEMW sets `stop_pend`. It never aborts an instruction mid-phase. A repeated `exec` while pending has no further effect.
- `exec` in HALT:
  - If `fault`=0, go to RUN at phase 0 (resume the next instruction).
  - If `fault`=1, ignore it; only reset clears a fault.
- `mem_ack` outside MEMW/phase 3 is ignored.
- `exec` and `mem_ack` in the same MEMW cycle: both take effect; the instruction completes, then the sequencer stops after WB.
- `reset` mid-instruction: IDLE next cycle, no strobes, counters cleared.
- `halted`=1 in HALT only.
- `phase_bus` = 1<<`phase` in RUN/MEMW, else 0.

Optional Feature:
- Macro: `PHASE_SINGLE_STEP_EN`.
- Defined: adds input `step` (1 bit).
  - `step` in IDLE or HALT (`fault`=0) runs exactly one instruction, with `stop_pend` preloaded, then returns to IDLE. HLT retired this way still goes to HALT.
  - `step` has priority over `exec` in the same cycle.
- Undefined: no `step` port; behaviour exactly as above.

Decomposition:
- Shared package `sps_pkg` holds:
  - state enum (IDLE, RUN, MEMW, HALT);
  - phase constants PH_IF..PH_WB;
  - opcode field constants for LD, ST, LI, CMP, OUT, HLT;
  - a function `is_wb(instr)` implementing `wb_en`, for reuse by the decode controller.
- One natural sub-module: `mem_wait_timer`, a load/count/expire timer for the MEMW timeout.

Test Plan:
- Reset, then `exec` with `instr`=16'hC0F0 (HLT). Required:
  - phases 0..4 on consecutive cycles;
  - `pc_we`=0 and `reg_we`=0 in WB;
  - `halted`=1;
  - `retired`=1.
- Run a LD (16'h0123) with `mem_ack` delayed 3 cycles. Required:
  - `mem_req` high for 4 cycles with `mem_we`=0;
  - `reg_we`=1 in WB;
  - total instruction length 8 cycles.
- Run a ST (16'h4123) with no `mem_ack` and `MEM_TMO`=15. Required:
  - `fault`=1 and `halted`=1 after 15 MEMW cycles;
  - a following `exec` is ignored;
  - only reset clears it.
- `exec` pulse during phase 2 of a CMP (op1=11, op3=0101). Required:
  - the instruction completes with `reg_we`=0 and `pc_we`=1;
  - the sequencer is IDLE the next cycle;
  - `phase_bus`=0.
- `reset` asserted in MEMW. Required:
  - the next cycle is IDLE with all strobes 0 and `retired`=0;
  - a late `mem_ack` is ignored.
- With `PHASE_SINGLE_STEP_EN`, pulse `step` on an LI (16'h8000). Required:
  - exactly 5 phases;
  - `reg_we`=1 in WB;
  - return to IDLE;
  - `retired` increments by 1.
